hamm_deco_pipe: RTL and testbench

HAMM_DECO_PIPE -- requirements
Module: hamm_deco_pipe

---
 rtl/hamm_pkg.sv | 38 +++
 rtl/hamm_syndrome.sv | 18 +
 rtl/hamm_deco_pipe.sv | 106 ++++++++++
 tb/tb_hamm_deco_pipe.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamm_pkg.sv
// Shared constants and helpers for the Hamming(21,16) decoder: code geometry,
// message-bit placement and syndrome classification.
package hamm_pkg;

    localparam int unsigned N_CODE  = 21;
    localparam int unsigned N_MSG   = 16;
    localparam int unsigned N_PAR   = 5;
    localparam int unsigned SYN_MAX = 21;

    // Code position of message bit m1..m16 (parity sits at the powers of two).
    localparam int unsigned DATA_POS [1:N_MSG] = '{
        3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, 17, 18, 19, 20, 21
    };

    typedef enum logic [1:0] {
        SYN_CLEAN,
        SYN_SINGLE,
        SYN_UNLOC
    } syn_class_t;

    function automatic syn_class_t classify(input logic [N_PAR-1:0] syn);
        if (syn == '0)
            return SYN_CLEAN;
        else if (32'(syn) <= SYN_MAX)
            return SYN_SINGLE;
        else
            return SYN_UNLOC;
    endfunction

    function automatic logic [1:N_MSG] extract(input logic [1:N_CODE] cw);
        logic [1:N_MSG] m;
        m = '0;
        for (int unsigned j = 1; j <= N_MSG; j++)
            m[j] = cw[DATA_POS[j]];
        return m;
    endfunction

endpackage

// File: rtl/hamm_syndrome.sv
// Combinational syndrome generator: bit k is the parity over every code
// position whose index has bit k set, parity bit included.
module hamm_syndrome
    import hamm_pkg::*;
(
    input  logic [1:N_CODE]    cw,
    output logic [N_PAR-1:0]   syn
);

    always_comb begin
        syn = '0;
        for (int unsigned k = 0; k < N_PAR; k++)
            for (int unsigned i = 1; i <= N_CODE; i++)
                if (i[k])
                    syn[k] = syn[k] ^ cw[i];
    end

endmodule

// File: rtl/hamm_deco_pipe.sv
// Two-stage Hamming(21,16) decoder with valid/ready flow control and
// saturating error-event counters.
module hamm_deco_pipe
    import hamm_pkg::*;
#(
    parameter int unsigned CNT_W = 16
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:N_CODE]    cw_in,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [1:N_MSG]     msg_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4:0]         syndrome,
    output logic               err_corr,
    output logic               err_uncorr,
    input  logic               clr_cnt,
    output logic [CNT_W-1:0]   corr_cnt,
    output logic [CNT_W-1:0]   uncorr_cnt
);

    logic               s1_valid;
    logic [1:N_CODE]    s1_cw;
    logic [N_PAR-1:0]   s1_syn;
    logic [N_PAR-1:0]   syn_c;

    logic               s1_load;
    logic               s2_load;
    logic               out_hs;

    logic [1:N_CODE]    fixed_cw;
    logic [1:N_MSG]     fixed_msg;
    syn_class_t         cls;

    hamm_syndrome u_syn (
        .cw  (cw_in),
        .syn (syn_c)
    );

    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;
    assign out_hs   = out_valid && out_ready;

    // Syndromes outside 1..21 never match a position, so the flip mask is
    // empty for both the clean and the unlocatable case.
    always_comb begin
        fixed_cw = s1_cw;
        for (int unsigned i = 1; i <= N_CODE; i++)
            if (s1_syn == 5'(i))
                fixed_cw[i] = ~s1_cw[i];
        fixed_msg = extract(fixed_cw);
        cls       = classify(s1_syn);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_cw    <= '0;
            s1_syn   <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_cw  <= cw_in;
                s1_syn <= syn_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            msg_out    <= '0;
            syndrome   <= '0;
            err_corr   <= 1'b0;
            err_uncorr <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                msg_out    <= fixed_msg;
                syndrome   <= s1_syn;
                err_corr   <= (cls == SYN_SINGLE);
                err_uncorr <= (cls == SYN_UNLOC);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (clr_cnt) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (out_hs) begin
            if (err_corr && corr_cnt != '1)
                corr_cnt <= corr_cnt + 1'b1;
            if (err_uncorr && uncorr_cnt != '1)
                uncorr_cnt <= uncorr_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hamm_deco_pipe.sv
// Scoreboard bench for hamm_deco_pipe: an independent encoder builds each
// codeword, expected results are queued at acceptance and checked on delivery.
module tb_hamm_deco_pipe;

    localparam int unsigned CW    = 4;
    localparam int unsigned CMAX  = (1 << CW) - 1;

    typedef struct {
        logic [1:16] msg;
        logic [4:0]  syn;
        logic        corr;
        logic        uncorr;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:21]   cw_in = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:16]   msg_out;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [4:0]    syndrome;
    logic          err_corr;
    logic          err_uncorr;
    logic          clr_cnt = 1'b0;
    logic [CW-1:0] corr_cnt;
    logic [CW-1:0] uncorr_cnt;

    int            n_checks = 0;
    int            n_fail   = 0;
    exp_t          sb[$];
    exp_t          cur_exp;
    int unsigned   exp_corr = 0;
    int unsigned   exp_unc  = 0;
    logic          pat_en = 1'b0;
    int unsigned   pcnt = 0;

    logic          prev_stall = 1'b0;
    logic [1:16]   hold_msg;
    logic [4:0]    hold_syn;
    logic          hold_corr;
    logic          hold_unc;

    hamm_deco_pipe #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cw_in      (cw_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .msg_out    (msg_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .syndrome   (syndrome),
        .err_corr   (err_corr),
        .err_uncorr (err_uncorr),
        .clr_cnt    (clr_cnt),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [1:21] encode(input logic [1:16] m);
        logic [1:21] c;
        int j;
        logic par;
        c = '0;
        j = 1;
        for (int p = 1; p <= 21; p++)
            if ((p & (p - 1)) != 0) begin
                c[p] = m[j];
                j++;
            end
        for (int k = 0; k < 5; k++) begin
            par = 1'b0;
            for (int p = 1; p <= 21; p++)
                if (((p >> k) & 1) == 1)
                    par = par ^ c[p];
            c[1 << k] = par;
        end
        return c;
    endfunction

    function automatic logic [1:16] data_of(input logic [1:21] c);
        logic [1:16] m;
        int j;
        m = '0;
        j = 1;
        for (int p = 1; p <= 21; p++)
            if ((p & (p - 1)) != 0) begin
                m[j] = c[p];
                j++;
            end
        return m;
    endfunction

    // Drive one word (f1/f2 = flipped positions, 0 for none) until accepted.
    task automatic send(input logic [1:16] m, input int f1, input int f2);
        logic [1:21] c;
        int s;
        logic acc;
        c = encode(m);
        if (f1 != 0) c[f1] = ~c[f1];
        if (f2 != 0) c[f2] = ~c[f2];
        s = f1 ^ f2;
        cur_exp.syn    = 5'(s);
        cur_exp.corr   = (s >= 1 && s <= 21);
        cur_exp.uncorr = (s >= 22);
        if (cur_exp.corr) begin
            logic [1:21] fx;
            fx = c;
            fx[s] = ~fx[s];
            cur_exp.msg = data_of(fx);
        end else begin
            cur_exp.msg = data_of(c);
        end
        cw_in    = c;
        in_valid = 1'b1;
        acc      = 1'b0;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) check("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        cw_in    = '0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100; t++) begin
            if (sb.size() == 0 && !out_valid) break;
            @(posedge clk);
            #1;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    always @(posedge clk) begin
        #1;
        if (pat_en) begin
            out_ready = (pcnt % 3 == 0);
            pcnt++;
        end
    end

    // Monitor: acceptance pushes, delivery pops and compares, stalls must hold.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_msg", 32'(msg_out), 32'(hold_msg));
                check("stall_syn", 32'(syndrome), 32'(hold_syn));
                check("stall_flags", {30'd0, err_corr, err_uncorr}, {30'd0, hold_corr, hold_unc});
            end
            prev_stall = out_valid && !out_ready;
            hold_msg   = msg_out;
            hold_syn   = syndrome;
            hold_corr  = err_corr;
            hold_unc   = err_uncorr;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("msg", 32'(msg_out), 32'(e.msg));
                    check("syn", 32'(syndrome), 32'(e.syn));
                    check("corr", 32'(err_corr), 32'(e.corr));
                    check("uncorr", 32'(err_uncorr), 32'(e.uncorr));
                    if (!clr_cnt) begin
                        if (e.corr && exp_corr != CMAX) exp_corr++;
                        if (e.uncorr && exp_unc != CMAX) exp_unc++;
                    end
                end
            end
            if (clr_cnt) begin
                exp_corr = 0;
                exp_unc  = 0;
            end
            if (in_valid && in_ready) sb.push_back(cur_exp);
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_msg", 32'(msg_out), 32'd0);
        check("rst_syn", 32'(syndrome), 32'd0);
        check("rst_corr_cnt", 32'(corr_cnt), 32'd0);
        check("rst_uncorr_cnt", 32'(uncorr_cnt), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Clean word and pipeline latency.
        send(16'hA5C3, 0, 0);
        idle_in();
        @(negedge clk);
        check("lat_s1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_s2", 32'(out_valid), 32'd1);
        check("clean_msg", 32'(msg_out), 32'hA5C3);
        @(posedge clk);
        #1;
        drain();

        // Single data error at position 13.
        send(16'hA5C3, 13, 0);
        idle_in();
        drain();
        check("corr_cnt_1", 32'(corr_cnt), 32'd1);

        // Double error aliasing to syndrome 31.
        send(16'h0000, 21, 10);
        idle_in();
        drain();
        check("uncorr_cnt_1", 32'(uncorr_cnt), 32'd1);

        // Parity-only error: data unchanged, still flagged as corrected.
        send(16'h1234, 16, 0);
        idle_in();
        drain();

        // Back-to-back stream under a 1,0,0 ready pattern.
        pcnt   = 0;
        pat_en = 1'b1;
        for (int i = 0; i < 8; i++)
            send(16'($urandom), 0, 1 + (i * 3) % 21);
        idle_in();
        drain();
        pat_en = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        check("corr_cnt_stream", 32'(corr_cnt), 32'(exp_corr));

        // Saturation: enough corrections to pass all-ones.
        for (int i = 0; i < 16; i++)
            send(16'($urandom), 1 + i, 0);
        idle_in();
        drain();
        check("corr_cnt_sat", 32'(corr_cnt), 32'(CMAX));
        check("corr_cnt_model", 32'(corr_cnt), 32'(exp_corr));

        // Clear coinciding with a counted handshake.
        send(16'h5A5A, 7, 0);
        idle_in();
        @(posedge clk);
        #1 clr_cnt = 1'b1;
        @(posedge clk);
        #1 clr_cnt = 1'b0;
        check("clr_wins", 32'(corr_cnt), 32'd0);
        check("clr_uncorr", 32'(uncorr_cnt), 32'd0);
        drain();

        // Reset with two words in flight.
        out_ready = 1'b0;
        send(16'h1111, 0, 0);
        send(16'h2222, 3, 0);
        idle_in();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_corr_cnt", 32'(corr_cnt), 32'd0);
        check("mid_rst_uncorr_cnt", 32'(uncorr_cnt), 32'd0);
        check("mid_rst_msg", 32'(msg_out), 32'd0);
        sb.delete();
        exp_corr = 0;
        exp_unc  = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        send(16'hBEEF, 5, 0);
        idle_in();
        drain();
        check("post_rst_corr_cnt", 32'(corr_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
